// File: rtl/axi_alu_if.sv
// AXI4-Lite slave channel bundle for the axi_alu register block.
interface axi_alu_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8
);
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    logic [ADDR_WIDTH-1:0] awaddr;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input  bresp, bvalid, output bready,
        output araddr, arvalid, input arready,
        input  rdata, rresp, rvalid, output rready
    );

    modport slave (
        input  awaddr, awvalid, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input  araddr, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/axi_alu.sv
// AXI4-Lite register-mapped ALU: two operands and an op select produce a
// registered result, status flags and a recompute counter.
module axi_alu #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic     s0_axi_aclk,
    input  logic     s0_axi_aresetn,
    axi_alu_if.slave s0_axi
);
    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam int unsigned IDX_W  = ADDR_WIDTH - 2;
    localparam int unsigned MSB    = DATA_WIDTH - 1;

    localparam logic [IDX_W-1:0] IDX_OPA    = IDX_W'(0);
    localparam logic [IDX_W-1:0] IDX_OPB    = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_CTRL   = IDX_W'(2);
    localparam logic [IDX_W-1:0] IDX_RESULT = IDX_W'(3);
    localparam logic [IDX_W-1:0] IDX_STATUS = IDX_W'(4);
    localparam logic [IDX_W-1:0] IDX_COUNT  = IDX_W'(5);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;

    typedef enum logic [2:0] {
        WR_IDLE,
        WR_ADDR,
        WR_DATA,
        WR_COMMIT,
        WR_RESP
    } wr_state_e;

    typedef enum logic {
        RD_IDLE,
        RD_RESP
    } rd_state_e;

    wr_state_e wr_state, wr_next;
    rd_state_e rd_state, rd_next;

    logic                  awready_q, wready_q, bvalid_q, arready_q, rvalid_q;
    logic [1:0]            bresp_q, rresp_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic [IDX_W-1:0]      aw_idx_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [STRB_W-1:0]     w_strb_q;

    logic [DATA_WIDTH-1:0] opa_q, opb_q, result_q, count_q;
    logic [2:0]            ctrl_op_q;
    logic [3:0]            status_q;
    logic                  recalc_q;

    logic aw_hs_c, w_hs_c, b_hs_c, ar_hs_c, r_hs_c;
    logic commit_c, wr_rw_c, count_clr_c;

    logic [IDX_W-1:0]      rd_idx_c;
    logic [DATA_WIDTH-1:0] rd_data_c;
    logic [1:0]            rd_resp_c;

    logic [DATA_WIDTH:0]   alu_sum_c;
    logic [DATA_WIDTH-1:0] alu_res_c;
    logic                  alu_carry_c, alu_ovf_c, alu_ill_c;
    logic [3:0]            alu_status_c;

    // Byte offset bits carry no meaning in a word-indexed map.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{s0_axi.awaddr[1:0], s0_axi.araddr[1:0]};

    assign s0_axi.awready = awready_q;
    assign s0_axi.wready  = wready_q;
    assign s0_axi.bvalid  = bvalid_q;
    assign s0_axi.bresp   = bresp_q;
    assign s0_axi.arready = arready_q;
    assign s0_axi.rvalid  = rvalid_q;
    assign s0_axi.rresp   = rresp_q;
    assign s0_axi.rdata   = rdata_q;

    assign aw_hs_c = s0_axi.awvalid && awready_q;
    assign w_hs_c  = s0_axi.wvalid && wready_q;
    assign b_hs_c  = bvalid_q && s0_axi.bready;
    assign ar_hs_c = s0_axi.arvalid && arready_q;
    assign r_hs_c  = rvalid_q && s0_axi.rready;

    assign commit_c    = (wr_state == WR_COMMIT);
    assign wr_rw_c     = commit_c && ((aw_idx_q == IDX_OPA) || (aw_idx_q == IDX_OPB) ||
                                      (aw_idx_q == IDX_CTRL));
    assign count_clr_c = commit_c && (aw_idx_q == IDX_CTRL) && w_strb_q[1] && w_data_q[8];

    function automatic logic [DATA_WIDTH-1:0] apply_strb(
        input logic [DATA_WIDTH-1:0] old_v,
        input logic [DATA_WIDTH-1:0] new_v,
        input logic [STRB_W-1:0]     strb
    );
        logic [DATA_WIDTH-1:0] merged;
        merged = old_v;
        for (int unsigned i = 0; i < STRB_W; i++) begin
            if (strb[i]) merged[8*i +: 8] = new_v[8*i +: 8];
        end
        return merged;
    endfunction

    // Write channel: AW and W are captured independently, commit once both are held.
    always_comb begin
        wr_next = wr_state;
        case (wr_state)
            WR_IDLE: begin
                if (aw_hs_c && w_hs_c) wr_next = WR_COMMIT;
                else if (aw_hs_c)      wr_next = WR_ADDR;
                else if (w_hs_c)       wr_next = WR_DATA;
            end
            WR_ADDR:   if (w_hs_c)  wr_next = WR_COMMIT;
            WR_DATA:   if (aw_hs_c) wr_next = WR_COMMIT;
            WR_COMMIT: wr_next = WR_RESP;
            WR_RESP:   if (b_hs_c)  wr_next = WR_IDLE;
            default:   wr_next = WR_IDLE;
        endcase
    end

    always_ff @(posedge s0_axi_aclk or negedge s0_axi_aresetn) begin
        if (!s0_axi_aresetn) begin
            wr_state  <= WR_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            aw_idx_q  <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
        end else begin
            wr_state  <= wr_next;
            awready_q <= (wr_next == WR_IDLE) || (wr_next == WR_DATA);
            wready_q  <= (wr_next == WR_IDLE) || (wr_next == WR_ADDR);
            bvalid_q  <= (wr_next == WR_RESP);
            if (aw_hs_c) aw_idx_q <= s0_axi.awaddr[ADDR_WIDTH-1:2];
            if (w_hs_c) begin
                w_data_q <= s0_axi.wdata;
                w_strb_q <= s0_axi.wstrb;
            end
            if (commit_c) bresp_q <= wr_rw_c ? RESP_OKAY : RESP_SLVERR;
        end
    end

    // Read data mux; CTRL exposes only the op field.
    assign rd_idx_c = s0_axi.araddr[ADDR_WIDTH-1:2];

    always_comb begin
        rd_data_c = '0;
        rd_resp_c = RESP_OKAY;
        case (rd_idx_c)
            IDX_OPA:    rd_data_c = opa_q;
            IDX_OPB:    rd_data_c = opb_q;
            IDX_CTRL:   rd_data_c = DATA_WIDTH'(ctrl_op_q);
            IDX_RESULT: rd_data_c = result_q;
            IDX_STATUS: rd_data_c = DATA_WIDTH'(status_q);
            IDX_COUNT:  rd_data_c = count_q;
            default:    rd_resp_c = RESP_SLVERR;
        endcase
    end

    always_comb begin
        rd_next = rd_state;
        case (rd_state)
            RD_IDLE: if (ar_hs_c) rd_next = RD_RESP;
            RD_RESP: if (r_hs_c)  rd_next = RD_IDLE;
            default: rd_next = RD_IDLE;
        endcase
    end

    always_ff @(posedge s0_axi_aclk or negedge s0_axi_aresetn) begin
        if (!s0_axi_aresetn) begin
            rd_state  <= RD_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
        end else begin
            rd_state  <= rd_next;
            arready_q <= (rd_next == RD_IDLE);
            rvalid_q  <= (rd_next == RD_RESP);
            if (ar_hs_c) begin
                rdata_q <= rd_data_c;
                rresp_q <= rd_resp_c;
            end
        end
    end

    // ALU datapath evaluated on the registered operands.
    always_comb begin
        alu_sum_c   = {1'b0, opa_q} + {1'b0, opb_q};
        alu_res_c   = '0;
        alu_carry_c = 1'b0;
        alu_ovf_c   = 1'b0;
        alu_ill_c   = 1'b0;
        case (ctrl_op_q)
            OP_ADD: begin
                alu_res_c   = alu_sum_c[DATA_WIDTH-1:0];
                alu_carry_c = alu_sum_c[DATA_WIDTH];
                alu_ovf_c   = (opa_q[MSB] == opb_q[MSB]) && (alu_res_c[MSB] != opa_q[MSB]);
            end
            OP_SUB: begin
                alu_res_c   = opa_q - opb_q;
                alu_carry_c = (opa_q < opb_q);
                alu_ovf_c   = (opa_q[MSB] != opb_q[MSB]) && (alu_res_c[MSB] != opa_q[MSB]);
            end
            OP_AND:  alu_res_c = opa_q & opb_q;
            OP_OR:   alu_res_c = opa_q | opb_q;
            OP_XOR:  alu_res_c = opa_q ^ opb_q;
            default: alu_ill_c = 1'b1;
        endcase
        alu_status_c = {alu_ill_c, alu_ovf_c, (alu_res_c == '0) && !alu_ill_c, alu_carry_c};
    end

    // Register file, recompute one cycle after any RW commit; clear beats increment.
    always_ff @(posedge s0_axi_aclk or negedge s0_axi_aresetn) begin
        if (!s0_axi_aresetn) begin
            opa_q     <= '0;
            opb_q     <= '0;
            ctrl_op_q <= '0;
            result_q  <= '0;
            status_q  <= '0;
            count_q   <= '0;
            recalc_q  <= 1'b0;
        end else begin
            recalc_q <= wr_rw_c;
            if (commit_c && (aw_idx_q == IDX_OPA)) opa_q <= apply_strb(opa_q, w_data_q, w_strb_q);
            if (commit_c && (aw_idx_q == IDX_OPB)) opb_q <= apply_strb(opb_q, w_data_q, w_strb_q);
            if (commit_c && (aw_idx_q == IDX_CTRL) && w_strb_q[0]) ctrl_op_q <= w_data_q[2:0];
            if (recalc_q) begin
                result_q <= alu_res_c;
                status_q <= alu_status_c;
            end
            if (count_clr_c)   count_q <= '0;
            else if (recalc_q) count_q <= count_q + DATA_WIDTH'(1);
        end
    end
endmodule

// File: tb/tb_axi_alu.sv
// Scoreboard bench for axi_alu: tasks push expected B/R responses, a negedge
// monitor pops and compares them as the DUT hands responses back.
module tb_axi_alu;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 8;

    localparam logic [AW-1:0] A_OPA    = 8'h00;
    localparam logic [AW-1:0] A_OPB    = 8'h04;
    localparam logic [AW-1:0] A_CTRL   = 8'h08;
    localparam logic [AW-1:0] A_RESULT = 8'h0C;
    localparam logic [AW-1:0] A_STATUS = 8'h10;
    localparam logic [AW-1:0] A_COUNT  = 8'h14;
    localparam logic [AW-1:0] A_HOLE   = 8'h3C;

    typedef struct {
        string          name;
        logic [DW-1:0]  data;
        logic [1:0]     resp;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;

    axi_alu_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) axi ();

    axi_alu #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .s0_axi_aclk   (clk),
        .s0_axi_aresetn(rst_n),
        .s0_axi        (axi)
    );

    always #5 clk = ~clk;

    int   n_cmp  = 0;
    int   n_err  = 0;
    int   b_seen = 0;
    int   r_seen = 0;
    exp_t exp_b[$];
    exp_t exp_r[$];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
        end
    endtask

    // Monitor: compare every completed B and R handshake against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && axi.bvalid && axi.bready) begin
            n_cmp++;
            if (exp_b.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_b: bresp=%0b with nothing expected", axi.bresp);
            end else begin
                e = exp_b.pop_front();
                if (axi.bresp !== e.resp) begin
                    n_err++;
                    $display("FAIL %s: bresp=%02b, required %02b", e.name, axi.bresp, e.resp);
                end
            end
            b_seen++;
        end
        if (rst_n && axi.rvalid && axi.rready) begin
            n_cmp++;
            if (exp_r.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_r: rdata=0x%08h with nothing expected", axi.rdata);
            end else begin
                e = exp_r.pop_front();
                if (axi.rdata !== e.data || axi.rresp !== e.resp) begin
                    n_err++;
                    $display("FAIL %s: rdata=0x%08h rresp=%02b, required rdata=0x%08h rresp=%02b",
                             e.name, axi.rdata, axi.rresp, e.data, e.resp);
                end
            end
            r_seen++;
        end
    end

    task automatic wait_b(input string name, input int target);
        int c = 0;
        while (b_seen < target && c < 64) begin
            @(posedge clk);
            c++;
        end
        if (b_seen < target) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: no write response within 64 cycles", name);
        end
    endtask

    task automatic wait_r(input string name, input int target);
        int c = 0;
        while (r_seen < target && c < 64) begin
            @(posedge clk);
            c++;
        end
        if (r_seen < target) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: no read response within 64 cycles", name);
        end
    endtask

    task automatic axi_write(input string name, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                             input logic [DW/8-1:0] strb, input logic [1:0] resp);
        int target;
        bit aw_go, w_go;
        exp_b.push_back('{name: name, data: '0, resp: resp});
        target = b_seen + 1;
        @(posedge clk); #1;
        axi.awaddr = addr; axi.awvalid = 1'b1;
        axi.wdata  = data; axi.wstrb   = strb; axi.wvalid = 1'b1;
        for (int c = 0; c < 64 && (axi.awvalid || axi.wvalid); c++) begin
            @(negedge clk);
            aw_go = axi.awvalid && axi.awready;
            w_go  = axi.wvalid && axi.wready;
            @(posedge clk); #1;
            if (aw_go) axi.awvalid = 1'b0;
            if (w_go)  axi.wvalid  = 1'b0;
        end
        if (axi.awvalid || axi.wvalid) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: awvalid=%0b wvalid=%0b not accepted within 64 cycles",
                     name, axi.awvalid, axi.wvalid);
            axi.awvalid = 1'b0;
            axi.wvalid  = 1'b0;
        end
        wait_b(name, target);
    endtask

    task automatic axi_read(input string name, input logic [AW-1:0] addr,
                            input logic [DW-1:0] data, input logic [1:0] resp);
        int target;
        bit ar_go;
        exp_r.push_back('{name: name, data: data, resp: resp});
        target = r_seen + 1;
        @(posedge clk); #1;
        axi.araddr = addr; axi.arvalid = 1'b1;
        for (int c = 0; c < 64 && axi.arvalid; c++) begin
            @(negedge clk);
            ar_go = axi.arready;
            @(posedge clk); #1;
            if (ar_go) axi.arvalid = 1'b0;
        end
        if (axi.arvalid) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: arvalid not accepted within 64 cycles", name);
            axi.arvalid = 1'b0;
        end
        wait_r(name, target);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_awready"}, DW'(axi.awready), '0);
        check({tag, "_wready"},  DW'(axi.wready),  '0);
        check({tag, "_arready"}, DW'(axi.arready), '0);
        check({tag, "_bvalid"},  DW'(axi.bvalid),  '0);
        check({tag, "_rvalid"},  DW'(axi.rvalid),  '0);
        check({tag, "_bresp"},   DW'(axi.bresp),   '0);
        check({tag, "_rresp"},   DW'(axi.rresp),   '0);
        check({tag, "_rdata"},   axi.rdata,        '0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int target;
        rst_n = 1'b0;
        axi.awaddr = '0; axi.awvalid = 1'b0;
        axi.wdata  = '0; axi.wstrb   = '0; axi.wvalid = 1'b0;
        axi.bready = 1'b1;
        axi.araddr = '0; axi.arvalid = 1'b0;
        axi.rready = 1'b1;

        repeat (3) @(posedge clk);
        #2;
        check_reset_outputs("rst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("post_rst_awready", DW'(axi.awready), 1);
        check("post_rst_wready",  DW'(axi.wready),  1);
        check("post_rst_arready", DW'(axi.arready), 1);

        // ADD with carry-out wrapping to zero
        axi_write("wr_opa_ff", A_OPA,  32'hFFFF_FFFF, 4'hF, 2'b00);
        axi_write("wr_opb_1",  A_OPB,  32'h0000_0001, 4'hF, 2'b00);
        axi_write("wr_ctrl_0", A_CTRL, 32'h0000_0000, 4'hF, 2'b00);
        axi_read("rd_opa_ff",      A_OPA,    32'hFFFF_FFFF, 2'b00);
        axi_read("add_wrap_res",   A_RESULT, 32'h0000_0000, 2'b00);
        axi_read("add_wrap_stat",  A_STATUS, 32'h0000_0003, 2'b00);
        axi_read("add_wrap_count", A_COUNT,  32'd3,         2'b00);

        // SUB: borrow, then signed overflow
        axi_write("wr_ctrl_sub", A_CTRL, 32'h1, 4'hF, 2'b00);
        axi_write("wr_opa_5",    A_OPA,  32'd5, 4'hF, 2'b00);
        axi_write("wr_opb_7",    A_OPB,  32'd7, 4'hF, 2'b00);
        axi_read("sub_borrow_res",  A_RESULT, 32'hFFFF_FFFE, 2'b00);
        axi_read("sub_borrow_stat", A_STATUS, 32'h0000_0001, 2'b00);
        axi_write("wr_opa_7f", A_OPA, 32'h7FFF_FFFF, 4'hF, 2'b00);
        axi_write("wr_opb_ff", A_OPB, 32'hFFFF_FFFF, 4'hF, 2'b00);
        axi_read("sub_ovf_res",  A_RESULT, 32'h8000_0000, 2'b00);
        axi_read("sub_ovf_stat", A_STATUS, 32'h0000_0005, 2'b00);

        // Logic ops and ADD overflow
        axi_write("wr_ctrl_and", A_CTRL, 32'h2, 4'hF, 2'b00);
        axi_read("and_res", A_RESULT, 32'h7FFF_FFFF, 2'b00);
        axi_write("wr_ctrl_xor", A_CTRL, 32'h4, 4'hF, 2'b00);
        axi_read("xor_res",  A_RESULT, 32'h8000_0000, 2'b00);
        axi_read("xor_stat", A_STATUS, 32'h0000_0000, 2'b00);
        axi_write("wr_ctrl_or", A_CTRL, 32'h3, 4'hF, 2'b00);
        axi_read("or_res", A_RESULT, 32'hFFFF_FFFF, 2'b00);
        axi_write("wr_ctrl_add", A_CTRL, 32'h0, 4'hF, 2'b00);
        axi_write("wr_opb_1b",   A_OPB,  32'h1, 4'hF, 2'b00);
        axi_read("add_ovf_res",  A_RESULT, 32'h8000_0000, 2'b00);
        axi_read("add_ovf_stat", A_STATUS, 32'h0000_0004, 2'b00);
        axi_read("count_13",     A_COUNT,  32'd13,        2'b00);

        // Writes to RO / unmapped words are rejected without side effects
        axi_write("wr_result_ro", A_RESULT, 32'h1234_5678, 4'hF, 2'b10);
        axi_write("wr_hole",      A_HOLE,   32'h1234_5678, 4'hF, 2'b10);
        axi_read("rd_hole",          A_HOLE,   32'h0000_0000, 2'b10);
        axi_read("ro_result_intact", A_RESULT, 32'h8000_0000, 2'b00);
        axi_read("ro_count_intact",  A_COUNT,  32'd13,        2'b00);

        // W leads AW by three cycles while B is back-pressured
        axi.bready = 1'b0;
        exp_b.push_back('{name: "late_aw_bresp", data: '0, resp: 2'b00});
        target = b_seen + 1;
        @(posedge clk); #1;
        axi.wdata = 32'd3; axi.wstrb = 4'hF; axi.wvalid = 1'b1;
        @(negedge clk);
        check("early_w_wready", DW'(axi.wready), 1);
        @(posedge clk); #1;
        axi.wvalid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("held_w_wready",  DW'(axi.wready),  0);
            check("held_w_awready", DW'(axi.awready), 1);
        end
        @(posedge clk); #1;
        axi.awaddr = A_OPA; axi.awvalid = 1'b1;
        @(negedge clk);
        check("late_aw_awready", DW'(axi.awready), 1);
        @(posedge clk); #1;
        axi.awvalid = 1'b0;
        @(negedge clk);
        check("commit_bvalid_low", DW'(axi.bvalid), 0);
        repeat (4) begin
            @(negedge clk);
            check("stall_bvalid",  DW'(axi.bvalid),  1);
            check("stall_bresp",   DW'(axi.bresp),   0);
            check("stall_awready", DW'(axi.awready), 0);
            check("stall_wready",  DW'(axi.wready),  0);
        end
        @(posedge clk); #1;
        axi.bready = 1'b1;
        wait_b("late_aw_bresp", target);
        @(negedge clk);
        check("after_b_awready", DW'(axi.awready), 1);
        check("after_b_wready",  DW'(axi.wready),  1);
        axi_read("late_aw_count", A_COUNT,  32'd14, 2'b00);
        axi_read("late_aw_res",   A_RESULT, 32'd4,  2'b00);

        // Single byte lane update, then illegal op
        axi_write("wr_opa_full",  A_OPA, 32'h1122_3344, 4'hF, 2'b00);
        axi_write("wr_opa_lane1", A_OPA, 32'hAABB_CCDD, 4'h2, 2'b00);
        axi_read("opa_lane1", A_OPA, 32'h1122_CC44, 2'b00);
        axi_write("wr_ctrl_ill", A_CTRL, 32'h5, 4'hF, 2'b00);
        axi_read("ill_res",   A_RESULT, 32'h0000_0000, 2'b00);
        axi_read("ill_stat",  A_STATUS, 32'h0000_0008, 2'b00);
        axi_read("ill_ctrl",  A_CTRL,   32'h0000_0005, 2'b00);
        axi_read("ill_count", A_COUNT,  32'd17,        2'b00);

        // Count clear, then a zero-strobe write still recomputes
        axi_write("wr_ctrl_clr", A_CTRL, 32'h0000_0100, 4'h3, 2'b00);
        axi_read("clr_count", A_COUNT,  32'd1,         2'b00);
        axi_read("clr_ctrl",  A_CTRL,   32'h0000_0000, 2'b00);
        axi_read("clr_res",   A_RESULT, 32'h1122_CC45, 2'b00);
        axi_write("wr_opb_nostrb", A_OPB, 32'hFFFF_FFFF, 4'h0, 2'b00);
        axi_read("nostrb_opb",   A_OPB,   32'h0000_0001, 2'b00);
        axi_read("nostrb_count", A_COUNT, 32'd2,         2'b00);

        // Reset with an AW captured and a read response stalled
        @(posedge clk); #1;
        axi.rready = 1'b0;
        axi.awaddr = A_OPA; axi.awvalid = 1'b1;
        axi.araddr = A_OPA; axi.arvalid = 1'b1;
        @(negedge clk);
        check("pre_rst_awready", DW'(axi.awready), 1);
        check("pre_rst_arready", DW'(axi.arready), 1);
        @(posedge clk); #1;
        axi.awvalid = 1'b0; axi.arvalid = 1'b0;
        @(negedge clk);
        check("pre_rst_rvalid", DW'(axi.rvalid), 1);
        check("pre_rst_rdata",  axi.rdata, 32'h1122_CC44);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #2;
        check_reset_outputs("midrst");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        axi.rready = 1'b1;
        repeat (2) @(posedge clk);
        axi_read("rst_opa",    A_OPA,    32'h0, 2'b00);
        axi_read("rst_result", A_RESULT, 32'h0, 2'b00);
        axi_read("rst_status", A_STATUS, 32'h0, 2'b00);
        axi_read("rst_count",  A_COUNT,  32'h0, 2'b00);
        axi_write("wr_opb_9", A_OPB, 32'd9, 4'hF, 2'b00);
        axi_read("post_rst_opb",   A_OPB,    32'd9, 2'b00);
        axi_read("post_rst_res",   A_RESULT, 32'd9, 2'b00);
        axi_read("post_rst_count", A_COUNT,  32'd1, 2'b00);

        repeat (4) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/axi_alu.md
AXI_ALU -- requirements
Module: axi_alu

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning register and AXI data width (multiple of 8, minimum 16).
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, meaning AXI byte-address width (minimum 5).
REQ-003 SHALL have port s0_axi_aclk, input, 1 bit: the single clock.
REQ-004 SHALL have port s0_axi_aresetn, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have write-address ports: s0_axi_awaddr in ADDR_WIDTH, s0_axi_awvalid in 1, s0_axi_awready out 1.
REQ-006 SHALL have write-data ports: s0_axi_wdata in DATA_WIDTH, s0_axi_wstrb in DATA_WIDTH/8, s0_axi_wvalid in 1, s0_axi_wready out 1.
REQ-007 SHALL have write-response ports: s0_axi_bresp out 2, s0_axi_bvalid out 1, s0_axi_bready in 1.
REQ-008 SHALL have read-address ports: s0_axi_araddr in ADDR_WIDTH, s0_axi_arvalid in 1, s0_axi_arready out 1.
REQ-009 SHALL have read-data ports: s0_axi_rdata out DATA_WIDTH, s0_axi_rresp out 2, s0_axi_rvalid out 1, s0_axi_rready in 1.

Function
REQ-010 SHALL decode word index addr[ADDR_WIDTH-1:2]; addr[1:0] ignored.
REQ-011 SHALL implement map: 0x00 OPA (RW), 0x04 OPB (RW), 0x08 CTRL (RW), 0x0C RESULT (RO), 0x10 STATUS (RO), 0x14 COUNT (RO).
REQ-012 SHALL define CTRL[2:0] = op: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR; codes 5-7 illegal; CTRL[8] = count-clear, write-only, always reads 0; other CTRL bits read 0.
REQ-013 SHALL define STATUS[0] carry (ADD carry-out / SUB borrow, i.e. OPA<OPB unsigned), [1] zero, [2] signed overflow (ADD/SUB only), [3] illegal op; others 0.
REQ-014 SHALL accept AW and W independently: awready high while no address held; wready high while no data held; each drops the cycle after its handshake.
REQ-015 SHALL commit a write in the first cycle both AW and W are held, applying wstrb per byte lane to RW registers only.
REQ-016 SHALL assert bvalid the cycle after commit, hold bvalid/bresp stable until bready, and re-raise awready/wready the cycle after the B handshake.
REQ-017 SHALL return bresp 2'b10 (SLVERR) for writes to RO or unmapped addresses with no register changed; otherwise 2'b00.
REQ-018 SHALL hold arready high when rvalid is low; on AR handshake assert rvalid next cycle with rdata = register value at the handshake cycle; hold rdata/rvalid/rresp until rready; arready low while rvalid high.
REQ-019 SHALL return rresp 2'b10 and rdata 0 for unmapped reads; otherwise 2'b00.
REQ-020 SHALL recompute RESULT and STATUS exactly one cycle after any committed write to OPA, OPB or CTRL (even with all strobes 0); arithmetic modulo 2^DATA_WIDTH.
REQ-021 SHALL, for illegal op, set RESULT 0, STATUS[3]=1, STATUS[2:0]=0.
REQ-022 SHALL increment COUNT on each recompute, wrapping from all-ones to 0.
REQ-023 SHALL, when CTRL[8] written 1 with wstrb[1]=1, clear COUNT in the commit cycle; a coincident increment is lost (clear wins).
REQ-024 SHALL, on a read accepted in the same cycle as a write commit or recompute, return the pre-update value.
REQ-025 SHALL serve read and write channels concurrently and independently.

Reset
REQ-026 SHALL, while s0_axi_aresetn low, force asynchronously: OPA, OPB, CTRL, RESULT, STATUS, COUNT = 0; awready=wready=arready=1 only after reset release (0 during reset); bvalid=rvalid=0; bresp=rresp=0; rdata=0.
REQ-027 SHALL discard any partially captured AW/W, pending B or R on reset assertion mid-transaction; first cycle after release is idle.

Verification
REQ-028 Write OPA=0xFFFFFFFF, OPB=1, CTRL=0 (strobes 0xF) -> bresp 0 each; read RESULT=0x0, STATUS=0x3, COUNT=3.
REQ-029 CTRL=1, OPA=5, OPB=7 -> RESULT=0xFFFFFFFE, STATUS[0]=1; OPA=0x7FFFFFFF, OPB=0xFFFFFFFF -> STATUS[2]=1.
REQ-030 W presented 3 cycles before AW, bready held low 4 cycles -> single commit, bvalid stable, no second accept until B handshake.
REQ-031 Write 0x0C and 0x3C, read 0x3C -> bresp 2'b10, no state change, rresp 2'b10 with rdata 0.
REQ-032 Write OPA byte lane 1 only (wstrb 0x2, data 0xAABBCCDD) over OPA=0x11223344 -> OPA=0x1122CC44; CTRL=5 -> RESULT 0, STATUS=0x8.
REQ-033 Assert reset with AW captured and rvalid high, rready low -> all outputs reset values, registers 0, next write completes normally.
